// File: rtl/pool2d_multi_ch_if.sv
// Stream interface for the multi-channel 2x2 pooling stage.
// The master side (upstream and consumer) drives the pixel beats, the mode and ack.
// The slave side (the pooling block) returns in_ready, the pooled pixels and done.
interface pool2d_multi_ch_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CHANNELS   = 4
);
   logic                           valid_in;
   logic                           in_ready;
   logic [CHANNELS*DATA_WIDTH-1:0] data_in;
   logic                           mode;
   logic                           valid_out;
   logic [CHANNELS*DATA_WIDTH-1:0] data_out;
   logic                           done;
   logic                           ack;

   modport master (
      output valid_in, data_in, mode, ack,
      input  in_ready, valid_out, data_out, done
   );

   modport slave (
      input  valid_in, data_in, mode, ack,
      output in_ready, valid_out, data_out, done
   );
endinterface

// File: rtl/pool2d_multi_ch.sv
// Streaming 2x2 / stride-2 signed pooling over CHANNELS parallel lanes.
// Raster-order pixels arrive one per accepted beat. The previous row is kept in a line
// buffer, and the previous column is kept in a pixel register. A pooled pixel is
// registered one cycle after the beat that completes its window.
// When the frame ends, done pulses and further input is blocked until ack.
// Optional feature macro: POOL_AVG_EN. When it is defined, mode selects between max (0)
// and average (1). When it is undefined, only signed max pooling is built and mode is
// ignored.
module pool2d_multi_ch #(
   parameter int DATA_WIDTH = 32,
   parameter int CHANNELS   = 4,
   parameter int WIDTH      = 56,
   parameter int HEIGHT     = 56
) (
   input logic              clk,
   input logic              reset,
   pool2d_multi_ch_if.slave bus
);
   localparam int BW = CHANNELS * DATA_WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);

   localparam logic [CW-1:0] LAST_COL     = CW'(WIDTH - 1);
   localparam logic [RW-1:0] LAST_ROW     = RW'(HEIGHT - 1);
   // Last column and last row that can still close a full 2x2 window.
   // With odd sizes, the trailing column and trailing row are dropped (floor).
   localparam logic [CW-1:0] LAST_WIN_COL = CW'(2 * (WIDTH / 2) - 1);
   localparam logic [RW-1:0] LAST_WIN_ROW = RW'(2 * (HEIGHT / 2) - 1);

   typedef enum logic {RUN, WAIT_ACK} state_t;

   state_t          state_reg, state_next;
   logic            in_ready;
   logic            accept;
   logic            last_pixel;
   logic            window;
   logic [CW-1:0]   col_reg, col_next;
   logic [RW-1:0]   row_reg, row_next;
   logic [CW-1:0]   rd_addr;

   logic [BW-1:0]   line_buf [WIDTH];
   logic [BW-1:0]   buf_rd;
   logic [BW-1:0]   prev_cur_reg;
   logic [BW-1:0]   prev_buf_reg;
   logic [BW-1:0]   pooled;

   logic            valid_out_reg;
   logic [BW-1:0]   data_out_reg;
   logic            done_reg;

   assign in_ready   = (state_reg == RUN);
   assign accept     = bus.valid_in & in_ready;
   assign last_pixel = (col_reg == LAST_COL) && (row_reg == LAST_ROW);
   assign window     = accept && row_reg[0] && col_reg[0] &&
                       (row_reg <= LAST_WIN_ROW) && (col_reg <= LAST_WIN_COL);

   // Frame state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= RUN;
      else       state_reg <= state_next;
   end

   // Next state: the last accepted pixel blocks input; ack releases it (ack ignored in RUN)
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:      if (bus.valid_in && last_pixel) state_next = WAIT_ACK;
         WAIT_ACK: if (bus.ack) state_next = RUN;
         default:  state_next = RUN;
      endcase
   end

   // Raster position following the current one (both wrap to 0 after the last pixel)
   always_comb begin
      col_next = col_reg;
      row_next = row_reg;
      if (col_reg == LAST_COL) begin
         col_next = '0;
         row_next = (row_reg == LAST_ROW) ? '0 : row_reg + RW'(1);
      end else begin
         col_next = col_reg + CW'(1);
      end
   end

   // Counters advance only on accepted beats; gaps freeze them
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_reg <= '0;
         row_reg <= '0;
      end else if (accept) begin
         col_reg <= col_next;
         row_reg <= row_next;
      end
   end

   // Prefetch the buffered-row entry for the column that the next beat will land in.
   // The read address and the write address always differ on an accepting cycle.
   assign rd_addr = accept ? col_next : col_reg;

   // Line buffer: store the current row and read back the previous row with a registered read.
   // Entries are not reset. A window only reads entries that were already written earlier
   // in the same frame.
   always_ff @(posedge clk) begin
      if (accept) line_buf[col_reg] <= bus.data_in;
      buf_rd <= line_buf[rd_addr];
   end

   // Left-hand column of the window, for the current row and for the buffered row
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_cur_reg <= '0;
         prev_buf_reg <= '0;
      end else if (accept) begin
         prev_cur_reg <= bus.data_in;
         prev_buf_reg <= buf_rd;
      end
   end

`ifdef POOL_AVG_EN
   logic mode_reg;

   // The pooling mode is captured on the first beat of a frame and held for the rest of it
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                          mode_reg <= 1'b0;
      else if (accept && col_reg == '0 && row_reg == '0)  mode_reg <= bus.mode;
   end
`else
   logic unused_mode;
   assign unused_mode = bus.mode;
`endif

   // Per-lane pooling of {buf[col-1], buf[col], cur[col-1], data_in}
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] a, b, c, d;
      logic signed [DATA_WIDTH-1:0] max_ab, max_cd, max_all;

      assign a       = prev_buf_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b       = buf_rd[gi*DATA_WIDTH +: DATA_WIDTH];
      assign c       = prev_cur_reg[gi*DATA_WIDTH +: DATA_WIDTH];
      assign d       = bus.data_in[gi*DATA_WIDTH +: DATA_WIDTH];
      assign max_ab  = (a > b) ? a : b;
      assign max_cd  = (c > d) ? c : d;
      assign max_all = (max_ab > max_cd) ? max_ab : max_cd;

`ifdef POOL_AVG_EN
      // The two guard bits hold the 4-term sum exactly. The arithmetic shift floors
      // toward -inf, and the quotient always fits back into DATA_WIDTH bits.
      logic signed [DATA_WIDTH+1:0] sum;
      logic signed [DATA_WIDTH-1:0] avg;
      assign sum = (DATA_WIDTH+2)'(a) + (DATA_WIDTH+2)'(b) +
                   (DATA_WIDTH+2)'(c) + (DATA_WIDTH+2)'(d);
      assign avg = DATA_WIDTH'(sum >>> 2);
      assign pooled[gi*DATA_WIDTH +: DATA_WIDTH] = mode_reg ? avg : max_all;
`else
      assign pooled[gi*DATA_WIDTH +: DATA_WIDTH] = max_all;
`endif
   end

   // Output register: one-cycle valid pulse, data held between pulses, done after last pixel
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_out_reg <= 1'b0;
         data_out_reg  <= '0;
         done_reg      <= 1'b0;
      end else begin
         valid_out_reg <= window;
         done_reg      <= accept && last_pixel;
         if (window) data_out_reg <= pooled;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.valid_out = valid_out_reg;
   assign bus.data_out  = data_out_reg;
   assign bus.done      = done_reg;
endmodule

// File: tb/tb_pool2d_multi_ch.sv
// Directed bench for pool2d_multi_ch.
// Three instances (4x4, 5x5 and 6x6) use two 16-bit lanes. Lane 0 carries the raster
// index and lane 1 carries its negation, unless a test says otherwise.
module tb_pool2d_multi_ch;
   localparam int DW = 16;
   localparam int CH = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   logic [31:0] exp4 [4];
   logic [31:0] exp5 [4];
   logic [31:0] exp6 [9];

   pool2d_multi_ch_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) if4 ();
   pool2d_multi_ch_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) if5 ();
   pool2d_multi_ch_if #(.DATA_WIDTH(DW), .CHANNELS(CH)) if6 ();

   pool2d_multi_ch #(.DATA_WIDTH(DW), .CHANNELS(CH), .WIDTH(4), .HEIGHT(4)) dut4 (
      .clk(clk), .reset(reset), .bus(if4.slave));
   pool2d_multi_ch #(.DATA_WIDTH(DW), .CHANNELS(CH), .WIDTH(5), .HEIGHT(5)) dut5 (
      .clk(clk), .reset(reset), .bus(if5.slave));
   pool2d_multi_ch #(.DATA_WIDTH(DW), .CHANNELS(CH), .WIDTH(6), .HEIGHT(6)) dut6 (
      .clk(clk), .reset(reset), .bus(if6.slave));

   always #5 clk = ~clk;

   function automatic logic [31:0] pk(input int l0, input int l1);
      return {16'(l1), 16'(l0)};
   endfunction

   function automatic logic [31:0] pix(input int i);
      return pk(i, -i);
   endfunction

   // Drive one cycle on the 4x4 instance; outputs are then sampled 1 ns after the edge
   task automatic drive4(input logic v, input logic [31:0] d);
      if4.valid_in = v;
      if4.data_in  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      vectors++;
      if (if4.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset in_ready got %b want 1", if4.in_ready); end
      vectors++;
      if (if4.valid_out !== 1'b0) begin miscompares++; $display("FAIL reset valid_out got %b want 0", if4.valid_out); end
      vectors++;
      if (if4.data_out !== 32'h0) begin miscompares++; $display("FAIL reset data_out got %h want 0", if4.data_out); end
      vectors++;
      if (if4.done !== 1'b0) begin miscompares++; $display("FAIL reset done got %b want 0", if4.done); end
      vectors++;
      if (if5.in_ready !== 1'b1 || if6.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset in_ready5/6 got %b/%b want 1/1", if5.in_ready, if6.in_ready);
      end
      $display("reset: checked idle outputs");
   endtask

   task automatic test_max_4x4;
      int   k;
      logic win;
      k = 0;
      if4.mode = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive4(1'b1, pix(i));
         win = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
         vectors++;
         if (if4.valid_out !== win) begin miscompares++; $display("FAIL max4 beat %0d valid_out got %b want %b", i, if4.valid_out, win); end
         if (win) begin
            vectors++;
            if (if4.data_out !== exp4[k]) begin miscompares++; $display("FAIL max4 beat %0d data_out got %h want %h", i, if4.data_out, exp4[k]); end
            k++;
         end else if (k > 0) begin
            vectors++;
            if (if4.data_out !== exp4[k-1]) begin miscompares++; $display("FAIL max4 hold beat %0d data_out got %h want %h", i, if4.data_out, exp4[k-1]); end
         end
         vectors++;
         if (if4.done !== (i == 15)) begin miscompares++; $display("FAIL max4 beat %0d done got %b want %b", i, if4.done, i == 15); end
         $display("max4: beat %0d valid_out=%b data_out=%h done=%b", i, if4.valid_out, if4.data_out, if4.done);
      end
      // ack is raised in the same cycle that done is high
      if4.valid_in = 1'b0;
      vectors++;
      if (if4.in_ready !== 1'b0) begin miscompares++; $display("FAIL max4 wait in_ready got %b want 0", if4.in_ready); end
      if4.ack = 1'b1;
      @(posedge clk);
      #1;
      if4.ack = 1'b0;
      vectors++;
      if (if4.in_ready !== 1'b1) begin miscompares++; $display("FAIL max4 release in_ready got %b want 1", if4.in_ready); end
      vectors++;
      if (if4.valid_out !== 1'b0 || if4.done !== 1'b0) begin
         miscompares++; $display("FAIL max4 after pulses valid_out/done got %b/%b want 0/0", if4.valid_out, if4.done);
      end
   endtask

   task automatic test_odd_5x5;
      int   k, r, c;
      logic win;
      k = 0;
      if5.mode = 1'b0;
      for (int i = 0; i < 25; i++) begin
         if5.valid_in = 1'b1;
         if5.data_in  = pix(i);
         @(posedge clk);
         #1;
         r = i / 5;
         c = i % 5;
         win = (r % 2 == 1) && (c % 2 == 1) && (r <= 3) && (c <= 3);
         vectors++;
         if (if5.valid_out !== win) begin miscompares++; $display("FAIL odd5 beat %0d valid_out got %b want %b", i, if5.valid_out, win); end
         if (win) begin
            vectors++;
            if (if5.data_out !== exp5[k]) begin miscompares++; $display("FAIL odd5 beat %0d data_out got %h want %h", i, if5.data_out, exp5[k]); end
            k++;
         end
         vectors++;
         if (if5.done !== (i == 24)) begin miscompares++; $display("FAIL odd5 beat %0d done got %b want %b", i, if5.done, i == 24); end
         $display("odd5: beat %0d valid_out=%b data_out=%h done=%b", i, if5.valid_out, if5.data_out, if5.done);
      end
      if5.valid_in = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (if5.done !== 1'b0) begin miscompares++; $display("FAIL odd5 done width got %b want 0", if5.done); end
      vectors++;
      if (if5.in_ready !== 1'b0) begin miscompares++; $display("FAIL odd5 wait in_ready got %b want 0", if5.in_ready); end
      if5.ack = 1'b1;
      @(posedge clk);
      #1;
      if5.ack = 1'b0;
      vectors++;
      if (if5.in_ready !== 1'b1) begin miscompares++; $display("FAIL odd5 release in_ready got %b want 1", if5.in_ready); end
   endtask

   task automatic test_avg;
      logic [31:0] d;
      logic [31:0] want;
      logic        win;
`ifdef POOL_AVG_EN
      want = pk(-3, 1);
`else
      want = pk(-1, 2);
`endif
      for (int i = 0; i < 16; i++) begin
         case (i)
            0:       d = pk(-1, 1);
            1:       d = pk(-2, 1);
            4:       d = pk(-3, 1);
            5:       d = pk(-4, 2);
            default: d = pk(0, 0);
         endcase
         // mode is only meaningful on the first beat; flipping it afterwards must not matter
         if4.mode = (i == 0);
         drive4(1'b1, d);
         win = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
         vectors++;
         if (if4.valid_out !== win) begin miscompares++; $display("FAIL avg beat %0d valid_out got %b want %b", i, if4.valid_out, win); end
         if (win) begin
            vectors++;
            if (if4.data_out !== ((i == 5) ? want : 32'h0)) begin
               miscompares++; $display("FAIL avg beat %0d data_out got %h want %h", i, if4.data_out, (i == 5) ? want : 32'h0);
            end
            $display("avg: beat %0d data_out=%h", i, if4.data_out);
         end
      end
      vectors++;
      if (if4.done !== 1'b1) begin miscompares++; $display("FAIL avg done got %b want 1", if4.done); end
      if4.valid_in = 1'b0;
      if4.mode     = 1'b0;
      if4.ack      = 1'b1;
      @(posedge clk);
      #1;
      if4.ack = 1'b0;
   endtask

   task automatic test_gaps;
      int   i, k, cyc;
      logic go, win;
      i = 0; k = 0; cyc = 0;
      if6.mode = 1'b0;
      while (i < 36 && cyc < 2000) begin
         go = 1'($urandom_range(0, 1));
         if6.valid_in = go;
         if6.data_in  = go ? pix(i) : 32'($urandom);
         vectors++;
         if (if6.in_ready !== 1'b1) begin miscompares++; $display("FAIL gaps cycle %0d in_ready got %b want 1", cyc, if6.in_ready); end
         @(posedge clk);
         #1;
         cyc++;
         win = go && ((i / 6) % 2 == 1) && ((i % 6) % 2 == 1);
         vectors++;
         if (if6.valid_out !== win) begin miscompares++; $display("FAIL gaps cycle %0d beat %0d valid_out got %b want %b", cyc, i, if6.valid_out, win); end
         if (win) begin
            vectors++;
            if (if6.data_out !== exp6[k]) begin miscompares++; $display("FAIL gaps out %0d data_out got %h want %h", k, if6.data_out, exp6[k]); end
            k++;
         end
         vectors++;
         if (if6.done !== (go && i == 35)) begin miscompares++; $display("FAIL gaps cycle %0d done got %b want %b", cyc, if6.done, go && i == 35); end
         $display("gaps: cycle %0d valid_in=%b beat %0d valid_out=%b data_out=%h", cyc, go, i, if6.valid_out, if6.data_out);
         if (go) i++;
      end
      if6.valid_in = 1'b0;
      vectors++;
      if (i != 36) begin miscompares++; $display("FAIL gaps timeout beats got %0d want 36", i); end
      vectors++;
      if (k != 9) begin miscompares++; $display("FAIL gaps output count got %0d want 9", k); end
      if6.ack = 1'b1;
      @(posedge clk);
      #1;
      if6.ack = 1'b0;
      vectors++;
      if (if6.in_ready !== 1'b1) begin miscompares++; $display("FAIL gaps release in_ready got %b want 1", if6.in_ready); end
   endtask

   task automatic test_reset_midframe;
      int   k, dones;
      logic win;
      k = 0; dones = 0;
      for (int i = 0; i < 9; i++) drive4(1'b1, pix(i + 100));
      if4.valid_in = 1'b0;
      // asynchronous assertion between clock edges
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (if4.data_out !== 32'h0) begin miscompares++; $display("FAIL midreset data_out got %h want 0", if4.data_out); end
      vectors++;
      if (if4.in_ready !== 1'b1 || if4.valid_out !== 1'b0 || if4.done !== 1'b0) begin
         miscompares++; $display("FAIL midreset ready/valid/done got %b/%b/%b want 1/0/0", if4.in_ready, if4.valid_out, if4.done);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive4(1'b1, pix(i));
         win = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
         vectors++;
         if (if4.valid_out !== win) begin miscompares++; $display("FAIL midreset beat %0d valid_out got %b want %b", i, if4.valid_out, win); end
         if (win) begin
            vectors++;
            if (if4.data_out !== exp4[k]) begin miscompares++; $display("FAIL midreset beat %0d data_out got %h want %h", i, if4.data_out, exp4[k]); end
            k++;
         end
         if (if4.done === 1'b1) dones++;
      end
      vectors++;
      if (dones != 1) begin miscompares++; $display("FAIL midreset done count got %0d want 1", dones); end
      $display("midreset: %0d outputs, %0d done", k, dones);
      if4.valid_in = 1'b0;
      if4.ack = 1'b1;
      @(posedge clk);
      #1;
      if4.ack = 1'b0;
   endtask

   task automatic test_ack_hold;
      int   k;
      logic win;
      k = 0;
      // ack high while running must be ignored
      for (int i = 0; i < 16; i++) begin
         if4.ack = (i < 15);
         drive4(1'b1, pix(i));
      end
      if4.ack = 1'b0;
      vectors++;
      if (if4.done !== 1'b1) begin miscompares++; $display("FAIL ackhold done got %b want 1", if4.done); end
      for (int j = 0; j < 10; j++) begin
         drive4(1'b1, pix(50));
         vectors++;
         if (if4.in_ready !== 1'b0 || if4.valid_out !== 1'b0 || if4.done !== 1'b0) begin
            miscompares++; $display("FAIL ackhold cycle %0d ready/valid/done got %b/%b/%b want 0/0/0", j, if4.in_ready, if4.valid_out, if4.done);
         end
         $display("ackhold: wait cycle %0d in_ready=%b", j, if4.in_ready);
      end
      // Beat 0 is already presented on the ack cycle; it must not be taken until the next cycle
      if4.ack = 1'b1;
      drive4(1'b1, pix(0));
      if4.ack = 1'b0;
      vectors++;
      if (if4.in_ready !== 1'b1) begin miscompares++; $display("FAIL ackhold release in_ready got %b want 1", if4.in_ready); end
      for (int i = 0; i < 16; i++) begin
         drive4(1'b1, pix(i));
         win = ((i / 4) % 2 == 1) && ((i % 4) % 2 == 1);
         vectors++;
         if (if4.valid_out !== win) begin miscompares++; $display("FAIL ackhold beat %0d valid_out got %b want %b", i, if4.valid_out, win); end
         if (win) begin
            vectors++;
            if (if4.data_out !== exp4[k]) begin miscompares++; $display("FAIL ackhold beat %0d data_out got %h want %h", i, if4.data_out, exp4[k]); end
            k++;
         end
      end
      vectors++;
      if (if4.done !== 1'b1) begin miscompares++; $display("FAIL ackhold second done got %b want 1", if4.done); end
      if4.valid_in = 1'b0;
      if4.ack = 1'b1;
      @(posedge clk);
      #1;
      if4.ack = 1'b0;
   endtask

   initial begin
      exp4 = '{pk(5, 0), pk(7, -2), pk(13, -8), pk(15, -10)};
      exp5 = '{pk(6, 0), pk(8, -2), pk(16, -10), pk(18, -12)};
      exp6 = '{pk(7, 0), pk(9, -2), pk(11, -4), pk(19, -12), pk(21, -14),
               pk(23, -16), pk(31, -24), pk(33, -26), pk(35, -28)};
      if4.valid_in = 1'b0; if4.data_in = '0; if4.mode = 1'b0; if4.ack = 1'b0;
      if5.valid_in = 1'b0; if5.data_in = '0; if5.mode = 1'b0; if5.ack = 1'b0;
      if6.valid_in = 1'b0; if6.data_in = '0; if6.mode = 1'b0; if6.ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      test_max_4x4();
      test_odd_5x5();
      test_avg();
      test_gaps();
      test_reset_midframe();
      test_ack_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
